// File: rtl/stash_scan_table_pkg.sv
// Shared configuration and derived sizes for the Path ORAM stash scan table.
// All widths of the block and its interface are fixed here.
package stash_scan_table_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    localparam int unsigned ORAML           = 4;
    localparam int unsigned ORAMU           = 32;
    localparam int unsigned ORAMZ           = 2;
    localparam int unsigned StashEAWidth    = 8;
    localparam int unsigned ORAMLP1         = ORAML + 1;
    localparam int unsigned BlocksOnPath    = ORAMZ * ORAMLP1;
    localparam int unsigned ScanTableAWidth = clog2(BlocksOnPath + 1);
    localparam int unsigned BCWidth         = clog2(ORAMZ + 1);
    localparam int unsigned LevelWidth      = clog2(ORAMLP1);

    localparam logic [StashEAWidth-1:0] SNULL = '1;

endpackage

// File: rtl/stash_scan_table_if.sv
// Candidate, scan and per-access control signals of the stash scan table.
// master drives the candidates and scan requests; slave is the table itself.
interface stash_scan_table_if;
    import stash_scan_table_pkg::*;

    logic                       PerAccessReset;
    logic                       ResetDone;
    logic [ORAML-1:0]           CurrentLeaf;
    logic [ORAML-1:0]           InLeaf;
    logic [ORAMU-1:0]           InPAddr;
    logic [StashEAWidth-1:0]    InSAddr;
    logic                       InValid;
    logic [StashEAWidth-1:0]    OutSAddr;
    logic                       OutAccepted;
    logic                       OutValid;
    logic [ScanTableAWidth-1:0] InSTAddr;
    logic                       InSTValid;
    logic                       InSTReset;
    logic [StashEAWidth-1:0]    OutSTAddr;
    logic                       OutSTValid;

    modport master (
        output PerAccessReset, CurrentLeaf, InLeaf, InPAddr, InSAddr, InValid,
        output InSTAddr, InSTValid, InSTReset,
        input  ResetDone, OutSAddr, OutAccepted, OutValid, OutSTAddr, OutSTValid
    );

    modport slave (
        input  PerAccessReset, CurrentLeaf, InLeaf, InPAddr, InSAddr, InValid,
        input  InSTAddr, InSTValid, InSTReset,
        output ResetDone, OutSAddr, OutAccepted, OutValid, OutSTAddr, OutSTValid
    );

endinterface

// File: rtl/stash_scan_table_onehot_to_bin.sv
// One-hot to binary encoder for the selected tree level.
module stash_scan_table_onehot_to_bin #(
    parameter int unsigned OneHotWidth = 5,
    parameter int unsigned BinWidth    = 3
) (
    input  logic [OneHotWidth-1:0] onehot_i,
    output logic [BinWidth-1:0]    bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < OneHotWidth; i++) begin
            if (onehot_i[i]) bin_o = bin_o | BinWidth'(i);
        end
    end

endmodule

// File: rtl/stash_scan_table.sv
// Write-back planner: places each accepted stash entry at the deepest free bucket slot on the path.
// Optional simulation checker and trace enabled by defining SCAN_TABLE_CHECK_EN.
module stash_scan_table
    import stash_scan_table_pkg::*;
(
    input logic               Clock,
    input logic               Reset,
    stash_scan_table_if.slave bus
);

    logic [ScanTableAWidth-1:0] init_q, init_d;
    logic                       reset_done;

    logic [ORAMLP1-1:0]  x, lowbit, common, full, space, level_oh;
    logic [LevelWidth-1:0] level_bin;
    logic [BCWidth-1:0]  cnt_sel;
    logic [BCWidth-1:0]  bcnt_q [ORAMLP1];
    logic [BCWidth-1:0]  bcnt_d [ORAMLP1];
    logic                accepted;

    logic [ScanTableAWidth-1:0] slot, addr;
    logic                       we;
    logic [StashEAWidth-1:0]    wdata, rdata_q;
    logic [StashEAWidth-1:0]    st_mem [BlocksOnPath];
    logic                       stvalid_q;
    logic [ORAMU-1:0]           unused_paddr;

    assign unused_paddr = bus.InPAddr;

    assign reset_done = (init_q == ScanTableAWidth'(BlocksOnPath));
    assign init_d     = reset_done ? init_q : init_q + 1'b1;

    always_ff @(posedge Clock) begin
        if (Reset) init_q <= '0;
        else       init_q <= init_d;
    end

    // Bits below the lowest differing leaf bit are levels the two paths share.
    always_comb begin
        x      = {bus.InLeaf, 1'b0} ^ {bus.CurrentLeaf, 1'b0};
        lowbit = x & (-x);
        common = lowbit - ORAMLP1'(1);
        full   = '0;
        for (int i = 0; i < ORAMLP1; i++) full[i] = (bcnt_q[i] == BCWidth'(ORAMZ));
        space  = common & ~full;
    end

    always_comb begin
        level_oh = '0;
        for (int i = 0; i < ORAMLP1; i++) begin
            if (space[i]) begin
                level_oh    = '0;
                level_oh[i] = 1'b1;
            end
        end
        cnt_sel = '0;
        for (int i = 0; i < ORAMLP1; i++) begin
            if (level_oh[i]) cnt_sel = cnt_sel | bcnt_q[i];
        end
    end

    stash_scan_table_onehot_to_bin #(
        .OneHotWidth (ORAMLP1),
        .BinWidth    (LevelWidth)
    ) u_level_bin (
        .onehot_i (level_oh),
        .bin_o    (level_bin)
    );

    assign accepted = bus.InValid & (|space);

    always_comb begin
        for (int i = 0; i < ORAMLP1; i++) begin
            bcnt_d[i] = bcnt_q[i];
            if (accepted && level_oh[i]) bcnt_d[i] = bcnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || bus.PerAccessReset) begin
            for (int i = 0; i < ORAMLP1; i++) bcnt_q[i] <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign slot = ScanTableAWidth'(ScanTableAWidth'(level_bin) * ScanTableAWidth'(ORAMZ))
                + ScanTableAWidth'(cnt_sel);

    always_comb begin
        addr = bus.InSTAddr;
        if (!reset_done)      addr = init_q;
        else if (bus.InValid) addr = slot;
        we    = accepted | bus.InSTReset | ~reset_done;
        wdata = (!reset_done || bus.InSTReset) ? SNULL : bus.InSAddr;
    end

    // Read-before-write: a scan read with InSTReset returns the old entry.
    always_ff @(posedge Clock) begin
        stvalid_q <= bus.InSTValid;
        rdata_q   <= (addr < ScanTableAWidth'(BlocksOnPath)) ? st_mem[addr] : SNULL;
        if (we && (addr < ScanTableAWidth'(BlocksOnPath))) st_mem[addr] <= wdata;
    end

    assign bus.ResetDone   = reset_done;
    assign bus.OutSAddr    = bus.InSAddr;
    assign bus.OutValid    = bus.InValid;
    assign bus.OutAccepted = accepted;
    assign bus.OutSTAddr   = rdata_q;
    assign bus.OutSTValid  = stvalid_q;

`ifdef SCAN_TABLE_CHECK_EN
    logic done_seen_q;

    task automatic check_table_empty(input string when_s);
        for (int i = 0; i < BlocksOnPath; i++) begin
            if (st_mem[i] !== SNULL) begin
                $error("scan table: entry %0d = %0h not empty at %s", i, st_mem[i], when_s);
                $fatal(1, "scan table: check halted simulation");
            end
        end
    endtask

    always @(posedge Clock) begin
        if (Reset) begin
            done_seen_q <= 1'b0;
        end else begin
            if (bus.InSTValid && (bus.InValid || accepted)) begin
                $error("scan table: candidate and scan request in the same cycle");
                $fatal(1, "scan table: check halted simulation");
            end
            if (reset_done && !done_seen_q) begin
                check_table_empty("init done");
                done_seen_q <= 1'b1;
            end
            if (bus.PerAccessReset) check_table_empty("per-access reset");
            if (bus.InValid) begin
                $display("scan table: X=%b Common=%b Full=%b Space=%b saddr=%0h %s",
                         x, common, full, space, bus.InSAddr,
                         accepted ? "accept" : "reject");
            end
        end
    end
`endif

endmodule

// File: tb/tb_stash_scan_table.sv
// Directed bench for stash_scan_table: init, level placement, bucket overflow, scan clear, resets.
module tb_stash_scan_table;
    import stash_scan_table_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stash_scan_table_if bus ();

    stash_scan_table dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int unsigned cycles;
        logic        done;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            done = bus.ResetDone;
        end
        check_val(tag, cycles, 10);
    endtask

    task automatic scan(input int unsigned a, input logic clr, input logic [7:0] exp);
        @(negedge clk);
        bus.InSTAddr  = ScanTableAWidth'(a);
        bus.InSTValid = 1'b1;
        bus.InSTReset = clr;
        @(posedge clk);
        #1;
        check_val($sformatf("scan_valid[%0d]", a), {31'd0, bus.OutSTValid}, 1);
        check_val($sformatf("scan_data[%0d]", a), {24'd0, bus.OutSTAddr}, {24'd0, exp});
        @(negedge clk);
        bus.InSTValid = 1'b0;
        bus.InSTReset = 1'b0;
    endtask

    task automatic cand(input logic [3:0] leaf, input logic [7:0] saddr, input logic exp_acc);
        @(negedge clk);
        bus.InLeaf  = leaf;
        bus.InSAddr = saddr;
        bus.InValid = 1'b1;
        #1;
        check_val($sformatf("accepted[%0h]", saddr), {31'd0, bus.OutAccepted}, {31'd0, exp_acc});
        check_val($sformatf("out_valid[%0h]", saddr), {31'd0, bus.OutValid}, 1);
        check_val($sformatf("out_saddr[%0h]", saddr), {24'd0, bus.OutSAddr}, {24'd0, saddr});
        @(negedge clk);
        bus.InValid = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.PerAccessReset = 1'b0;
        bus.CurrentLeaf    = '0;
        bus.InLeaf         = '0;
        bus.InPAddr        = 32'h1234_5678;
        bus.InSAddr        = '0;
        bus.InValid        = 1'b0;
        bus.InSTAddr       = '0;
        bus.InSTValid      = 1'b0;
        bus.InSTReset      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_done_in_reset", {31'd0, bus.ResetDone}, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_done("init_latency");
        check_val("st_valid_idle", {31'd0, bus.OutSTValid}, 0);

        for (int i = 0; i < 10; i++) scan(i, 1'b0, 8'hFF);

        // Same leaf: whole path shared, fills the leaf bucket then spills upward.
        bus.CurrentLeaf = 4'b0101;
        cand(4'b0101, 8'd7, 1'b1);
        cand(4'b0101, 8'd9, 1'b1);
        cand(4'b0101, 8'd11, 1'b1);

        // Only the root is shared; third candidate overflows.
        bus.CurrentLeaf = 4'b0000;
        cand(4'b0001, 8'd20, 1'b1);
        cand(4'b0001, 8'd21, 1'b1);
        cand(4'b0001, 8'd22, 1'b0);

        scan(9, 1'b0, 8'd9);
        scan(6, 1'b0, 8'd11);
        scan(0, 1'b0, 8'd20);
        scan(1, 1'b0, 8'd21);
        scan(2, 1'b0, 8'hFF);
        scan(8, 1'b1, 8'd7);
        scan(8, 1'b0, 8'hFF);

        @(negedge clk);
        bus.PerAccessReset = 1'b1;
        @(negedge clk);
        bus.PerAccessReset = 1'b0;
        cand(4'b0001, 8'd30, 1'b1);
        cand(4'b0100, 8'd40, 1'b1);
        scan(0, 1'b0, 8'd30);
        scan(4, 1'b0, 8'd40);
        cand(4'b0001, 8'd31, 1'b1);

        // Reset mid-access: counts cleared and table re-initialised.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_done("reinit_latency");
        scan(0, 1'b0, 8'hFF);
        scan(1, 1'b0, 8'hFF);
        scan(4, 1'b0, 8'hFF);
        cand(4'b0001, 8'd50, 1'b1);
        cand(4'b0001, 8'd51, 1'b1);
        cand(4'b0001, 8'd52, 1'b0);
        scan(0, 1'b0, 8'd50);
        scan(1, 1'b0, 8'd51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stash_scan_table.md
Name: stash_scan_table

Overview:
- Per-access write-back planner for the Path ORAM stash.
- For each candidate stash entry (InLeaf, InSAddr), it finds the deepest non-full bucket shared between the block's leaf and the current access path.
- On a hit it records the stash address in a scan table at slot level*ORAMZ + occupancy.
- The stash write-back engine then scans the table in address order, clearing slots as it reads them.

Parameters:
- ORAML, 4: leaf-label width (tree depth). Derived ORAMLP1 = ORAML+1 levels; level 0 is the root.
- ORAMU, 32: program-address width; debug only.
- ORAMZ, 2: blocks per bucket. Must be a power of two.
- StashEAWidth, 8: stash entry address width.
- BlocksOnPath, ORAMZ*ORAMLP1 (10): scan table depth.
- ScanTableAWidth, clog2(BlocksOnPath+1) (4).
- BCWidth, clog2(ORAMZ+1) (2): per-bucket counter width.

Ports:
- Clock  in  1: single clock.
- Reset  in  1: synchronous, active-high.
- PerAccessReset  in  1: clears bucket counts.
- ResetDone  out  1: table initialisation complete.
- CurrentLeaf  in  ORAML: leaf of the current access path.
- InLeaf  in  ORAML: candidate block's leaf.
- InPAddr  in  ORAMU: debug only, functionally unused.
- InSAddr  in  StashEAWidth: candidate stash address.
- InValid  in  1: candidate present.
- OutSAddr  out  StashEAWidth: equals InSAddr.
- OutAccepted  out  1: candidate will be written back.
- OutValid  out  1: equals InValid.
- InSTAddr  in  ScanTableAWidth: scan read address.
- InSTValid  in  1: scan read request.
- InSTReset  in  1: write SNULL to InSTAddr.
- OutSTAddr  out  StashEAWidth: scan read data.
- OutSTValid  out  1: InSTValid delayed by one cycle.

Behaviour:
- SNULL = all ones (0xFF at default width).
- Init counter:
  - Cleared by Reset; increments each cycle while ResetDone=0.
  - ResetDone = (count == BlocksOnPath).
  - While not done, writes SNULL at address = count; the table is all SNULL after BlocksOnPath cycles.
- Matching (combinational):
  - X = {InLeaf,0} ^ {CurrentLeaf,0}.
  - Common = (X & -X) - 1. Equal leaves give X=0, so Common = all ones.
  - Space = Common & ~Full, where Full[i] = (count[i] == ORAMZ).
  - Level = index of the most-significant set bit of Space (one-hot, then binary).
  - OutAccepted = InValid & (Space != 0).
- Bucket counts:
  - ORAMLP1 registers of BCWidth bits each.
  - Cleared by Reset or PerAccessReset. PerAccessReset does not touch the table.
  - On OutAccepted, count[Level] increments by 1.
- Table RAM:
  - BlocksOnPath x StashEAWidth, synchronous, one-cycle read latency, read-before-write on the same address.
  - Address priority: ~ResetDone → init count; else InValid → Level*ORAMZ + count[Level]; else InSTAddr.
  - Write enable = OutAccepted | InSTReset | ~ResetDone.
  - Write data = SNULL when ~ResetDone or InSTReset, else InSAddr.
- OutSTValid: registered, not reset, equals InSTValid one cycle earlier.
- InValid and InSTValid in the same cycle is illegal; the scan request is lost.
- Reset mid-scan restarts initialisation and clears counts.

Optional Feature:
- SCAN_TABLE_CHECK_EN.
- When defined, simulation-only checks flag an error and halt:
  - InValid or OutAccepted coinciding with InSTValid.
  - Any table entry not equal to SNULL at PerAccessReset or at the rising edge of ResetDone.
- A verbose trace prints X, Common, Full, Space and the accept/reject decision per candidate.
- When undefined, no checker logic and no behavioural difference.

Decomposition:
- Shared package holds: ORAMLP1, BCWidth, BlocksOnPath, ScanTableAWidth, SNULL, and a clog2 function.
- Reuse the codebase's generic Counter (init), Register (bucket counts), Reverse, Mux (one-hot select of count[Level]) and RAM.
- The one natural sub-module is onehot_to_bin (one-hot level to binary).

Test Plan:
- Reset, then idle → ResetDone rises exactly 10 cycles after Reset drops; scan reads of addresses 0..9 return 0xFF.
- CurrentLeaf=InLeaf=4'b0101:
  - SAddr=7 → accepted, table[8]=7.
  - SAddr=9 → table[9]=9.
  - Third candidate → Level 3, table[6].
- CurrentLeaf=0000, InLeaf=0001 (root only):
  - First two candidates → table[0], table[1].
  - Third → OutAccepted=0, OutValid=1, OutSAddr=InSAddr.
- After the root fills, pulse PerAccessReset; the next root-only candidate → written at address 0 again.
- Scan InSTAddr=8 with InSTValid=1 and InSTReset=1 → next cycle OutSTValid=1 and OutSTAddr=7; re-reading address 8 returns 0xFF.
- Assert Reset mid-access → counts are zero and the table is re-initialised to SNULL within 10 cycles.
